// File: rtl/varint_pkg.sv
// Shared types and helpers for the varint (LEB128) encoder.
package varint_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } varint_state_e;

  // Number of 7-bit groups needed to hold a w-bit value.
  function automatic int varint_max_bytes(int w);
    return (w + 6) / 7;
  endfunction

  // Encoded length in bytes of the low 'width' bits of value.
  function automatic int varint_len(logic [63:0] value, int width);
    logic [63:0] v;
    int n;
    v = (width >= 64) ? value : (value & ((64'd1 << width) - 64'd1));
    n = 1;
    for (int i = 7; i < 64; i += 7) begin
      if ((v >> i) != 64'd0) n = i / 7 + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/varint_zigzag.sv
// Protobuf sint (zigzag) mapping: small-magnitude signed values become small unsigned values.
module varint_zigzag #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              zigzag_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (zigzag_i) data_o = (data_i << 1) ^ {DATA_W{data_i[DATA_W-1]}};
  end

endmodule

// File: rtl/varint_encoder.sv
// Width-generic LEB128 varint encoder, one byte per cycle with back-to-back values.
// Optional zigzag pre-transform is enabled by defining VARINT_ZIGZAG_EN.
module varint_encoder
  import varint_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = $clog2(varint_max_bytes(DATA_W) + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_zigzag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [7:0]        out_data_o,
  output logic              out_last_o,
  output logic [LEN_W-1:0]  out_len_o,
  output logic              dbg_state_o,
  output logic [LEN_W-1:0]  dbg_cnt_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and the output byte is held while
  // out_valid_o is high and out_ready_i is low.

  varint_state_e     state_q;
  logic [DATA_W-1:0] shreg_q, shreg_d, load_val;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_last_q;
  logic [7:0]        out_data_q;
  logic [LEN_W-1:0]  out_len_q;
  logic              accept, out_hs;

`ifdef VARINT_ZIGZAG_EN
  varint_zigzag #(.DATA_W(DATA_W)) u_zigzag (
    .data_i   (in_data_i),
    .zigzag_i (in_zigzag_i),
    .data_o   (load_val)
  );
`else
  logic unused_zigzag;
  assign unused_zigzag = in_zigzag_i;
  assign load_val      = in_data_i;
`endif

  function automatic logic more_groups(logic [DATA_W-1:0] v);
    return |(v >> 7);
  endfunction

  function automatic logic [7:0] byte_of(logic [DATA_W-1:0] v);
    return {more_groups(v), v[6:0]};
  endfunction

  // A new value may enter while the last byte of the previous one leaves.
  assign in_ready_o = ~reset & ((state_q == IDLE) |
                                ((state_q == EMIT) & out_last_q & out_ready_i));
  assign accept     = in_valid_i & in_ready_o;
  assign out_hs     = out_valid_q & out_ready_i;
  assign shreg_d    = shreg_q >> 7;
  assign cnt_d      = cnt_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      out_len_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= EMIT;
            shreg_q     <= load_val;
            cnt_q       <= LEN_W'(1);
            out_valid_q <= 1'b1;
            out_data_q  <= byte_of(load_val);
            out_last_q  <= ~more_groups(load_val);
            out_len_q   <= more_groups(load_val) ? '0 : LEN_W'(1);
          end
        end
        EMIT: begin
          if (accept) begin
            shreg_q     <= load_val;
            cnt_q       <= LEN_W'(1);
            out_valid_q <= 1'b1;
            out_data_q  <= byte_of(load_val);
            out_last_q  <= ~more_groups(load_val);
            out_len_q   <= more_groups(load_val) ? '0 : LEN_W'(1);
          end else if (out_hs) begin
            if (!out_last_q) begin
              shreg_q    <= shreg_d;
              cnt_q      <= cnt_d;
              out_data_q <= byte_of(shreg_d);
              out_last_q <= ~more_groups(shreg_d);
              out_len_q  <= more_groups(shreg_d) ? '0 : cnt_d;
            end else begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_data_q  <= 8'h00;
              out_last_q  <= 1'b0;
              out_len_q   <= '0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_data_q  <= 8'h00;
          out_last_q  <= 1'b0;
          out_len_q   <= '0;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_len_o   = out_len_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_varint_encoder.sv
// Bench for varint_encoder: vector table, hand sequences and random values vs. an arithmetic model.
module tb_varint_encoder;
  import varint_pkg::*;

  localparam int DW   = 32;
  localparam int LW   = $clog2(varint_max_bytes(DW) + 1);
  localparam int LW64 = $clog2(varint_max_bytes(64) + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready, in_zigzag, out_valid, out_ready, out_last, dbg_state;
  logic [DW-1:0] in_data;
  logic [7:0]    out_data;
  logic [LW-1:0] out_len, dbg_cnt;

  logic            in_valid_64, in_ready_64, out_valid_64, out_last_64, dbg_state_64;
  logic            in_zigzag_64, out_ready_64;
  logic [63:0]     in_data_64;
  logic [7:0]      out_data_64;
  logic [LW64-1:0] out_len_64, dbg_cnt_64;

  varint_encoder #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_zigzag_i(in_zigzag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .out_len_o(out_len),
    .dbg_state_o(dbg_state), .dbg_cnt_o(dbg_cnt)
  );

  varint_encoder #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid_64), .in_ready_o(in_ready_64), .in_data_i(in_data_64),
    .in_zigzag_i(in_zigzag_64),
    .out_valid_o(out_valid_64), .out_ready_i(out_ready_64), .out_data_o(out_data_64),
    .out_last_o(out_last_64), .out_len_o(out_len_64),
    .dbg_state_o(dbg_state_64), .dbg_cnt_o(dbg_cnt_64)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  logic [16:0] exp_q[$];    // {len[7:0], last, data[7:0]}
  logic [16:0] exp64_q[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: sint mapping on the signed value, then base-128 digits.
  function automatic logic [63:0] model_xform(logic [63:0] x, logic zz);
`ifdef VARINT_ZIGZAG_EN
    longint s;
    if (!zz) return x;
    s = longint'($signed(x[31:0]));
    return (s >= 0) ? 64'(2 * s) : 64'(-2 * s - 1);
`else
    return (zz === 1'bx) ? 64'd0 : x;
`endif
  endfunction

  task automatic push_model(logic [63:0] v, int which);
    logic [63:0] r;
    logic [6:0]  grp;
    logic        last_b;
    int          total;
    total = 0;
    r = v;
    do begin total++; r = r / 128; end while (r != 0);
    r = v;
    for (int i = 1; i <= total; i++) begin
      grp    = 7'(r % 128);
      r      = r / 128;
      last_b = (i == total);
      if (which == 0) exp_q.push_back({8'(last_b ? total : 0), last_b, ~last_b, grp});
      else            exp64_q.push_back({8'(last_b ? total : 0), last_b, ~last_b, grp});
    end
  endtask

  logic        held_v = 1'b0;
  logic [17:0] held;
  always @(negedge clk) begin
    logic [16:0] cur;
    if (reset) held_v = 1'b0;
    else begin
      cur = {8'(out_len), out_last, out_data};
      if (held_v) check("stall_hold", {out_valid, cur}, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL extra_byte: got 0x%0h, expected no byte", cur);
        end else check("byte", cur, exp_q.pop_front());
      end
      held_v = out_valid && !out_ready;
      held   = {out_valid, cur};
    end
  end

  always @(negedge clk) begin
    logic [16:0] cur;
    if (!reset && out_valid_64 && out_ready_64) begin
      cur = {8'(out_len_64), out_last_64, out_data_64};
      if (exp64_q.size() == 0) begin
        checks++;
        $display("FAIL extra_byte64: got 0x%0h, expected no byte", cur);
      end else check("byte64", cur, exp64_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  int rdy_mode = 2;  // 0: always ready, 1: random, 2: driven by the test
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Leaves in_valid high; the caller drops it unless another value follows.
  task automatic send(logic [31:0] v, logic zz);
    int guard;
    in_valid = 1'b1; in_data = v; in_zigzag = zz; guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) begin
        checks++;
        $display("FAIL send_timeout: got no in_ready, expected in_ready within 200 cycles");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send64(logic [63:0] v);
    int guard;
    in_valid_64 = 1'b1; in_data_64 = v; guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready_64) break;
      guard++;
      if (guard > 200) begin
        checks++;
        $display("FAIL send64_timeout: got no in_ready, expected in_ready within 200 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid_64 = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || exp64_q.size() != 0) && guard < 1000) begin
      @(posedge clk); guard++;
    end
    @(posedge clk); #1;
    check("drain", exp_q.size() + exp64_q.size(), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [31:0] value;
    logic        zz;
    logic [3:0]  n;
    logic [39:0] bytes;  // byte 0 in [7:0]
  } vec_t;
  vec_t vecs[$];

  int   b2b_data[5]  = '{1, 128, 5, 5, 0};
  logic b2b_valid[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic b2b_ir[5]    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic b2b_ov[5]    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  pat;
    logic [7:0]  b;
    logic [31:0] v;
    int          nb;

    vecs.push_back('{32'd0,          1'b0, 4'd1, 40'h00});
    vecs.push_back('{32'd300,        1'b0, 4'd2, 40'h02AC});
    vecs.push_back('{32'hFFFF_FFFF,  1'b0, 4'd5, 40'h0F_FFFF_FFFF});
    vecs.push_back('{32'd1,          1'b0, 4'd1, 40'h01});
    vecs.push_back('{32'd128,        1'b0, 4'd2, 40'h0180});
    vecs.push_back('{32'd5,          1'b0, 4'd1, 40'h05});
`ifdef VARINT_ZIGZAG_EN
    vecs.push_back('{32'hFFFF_FFFF,  1'b1, 4'd1, 40'h01});
    vecs.push_back('{32'd1,          1'b1, 4'd1, 40'h02});
`else
    vecs.push_back('{32'hFFFF_FFFF,  1'b1, 4'd5, 40'h0F_FFFF_FFFF});
    vecs.push_back('{32'd1,          1'b1, 4'd1, 40'h01});
`endif

    // reset state
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_zigzag = 1'b0; out_ready = 1'b0;
    in_valid_64 = 1'b0; in_data_64 = '0; in_zigzag_64 = 1'b0; out_ready_64 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_len", out_len, 0);
    check("rst_cnt", dbg_cnt, 0);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // table vectors, out_ready held high
    rdy_mode = 0;
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      for (int i = 0; i < int'(vecs[k].n); i++) begin
        b = vecs[k].bytes[8*i +: 8];
        exp_q.push_back({(i == int'(vecs[k].n) - 1) ? 8'(vecs[k].n) : 8'd0,
                         i == int'(vecs[k].n) - 1, b});
      end
      send(vecs[k].value, vecs[k].zz);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end
    drain();

    // backpressure on 300: ready pattern 0,1,0,0,1
    rdy_mode = 2;
    out_ready = 1'b0;
    push_model(64'd300, 0);
    in_valid = 1'b1; in_data = 32'd300; in_zigzag = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pat = 5'b10010;
    for (int k = 0; k < 5; k++) begin
      out_ready = pat[k];
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_idle_after", out_valid, 0);
    check("bp_consumed", exp_q.size(), 0);
    rdy_mode = 0;
    @(posedge clk); #1;

    // back-to-back 1, 128, 5
    out_ready = 1'b1;
    push_model(64'd1, 0);
    push_model(64'd128, 0);
    push_model(64'd5, 0);
    for (int k = 0; k < 5; k++) begin
      in_valid = b2b_valid[k];
      in_data  = 32'(b2b_data[k]);
      @(negedge clk);
      check($sformatf("b2b_in_ready_%0d", k), in_ready, b2b_ir[k]);
      check($sformatf("b2b_out_valid_%0d", k), out_valid, b2b_ov[k]);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("b2b_idle_after", out_valid, 0);
    @(posedge clk); #1;
    drain();

    // reset on the second byte of 300
    exp_q.push_back({8'd0, 1'b0, 8'hAC});
    send(32'd300, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_cnt", dbg_cnt, 0);
    check("midrst_in_ready_after", in_ready, 1);
    @(posedge clk); #1;
    push_model(64'd5, 0);
    send(32'd5, 1'b0);
    in_valid = 1'b0;
    drain();

    // random values with random back-pressure and gaps
    rdy_mode = 1;
    for (int k = 0; k < 150; k++) begin
      nb = $urandom_range(0, 32);
      v  = (nb == 0) ? 32'd0 : ($urandom & (32'hFFFF_FFFF >> (32 - nb)));
      in_zigzag = 1'($urandom_range(0, 1));
      push_model(model_xform({32'd0, v}, in_zigzag) & 64'hFFFF_FFFF, 0);
      send(v, in_zigzag);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    drain();

    // 64-bit instance: all ones gives nine 0xFF then 0x01
    for (int i = 0; i < 9; i++) exp64_q.push_back({8'd0, 1'b0, 8'hFF});
    exp64_q.push_back({8'd10, 1'b1, 8'h01});
    send64(64'hFFFF_FFFF_FFFF_FFFF);
    push_model(64'd0, 1);
    send64(64'd0);
    push_model(64'h8000_0000_0000_0000, 1);
    send64(64'h8000_0000_0000_0000);
    for (int k = 0; k < 10; k++) begin
      in_data_64 = {$urandom, $urandom} >> $urandom_range(0, 63);
      push_model(in_data_64, 1);
      send64(in_data_64);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/varint_encoder.md
# varint_encoder

Parametrised protobuf varint (LEB128) encoder for the serializer datapath, sitting between the field-value FIFO and the byte-output FIFO. It accepts one unsigned integer of DATA_W bits per ready/valid handshake and emits it least-significant group first as 7-bit groups. Bit 7 of each byte is the continuation flag, and the final byte is flagged with its byte count. It replaces the fixed 32-bit FIFO-pop encoder with a width-generic, back-pressure-aware, back-to-back-capable engine.

## Interface
Parameters:
- DATA_W, 32, input integer width; legal values 8..64.
- LEN_W, $clog2(MAX_BYTES+1), width of out_len; MAX_BYTES = ceil(DATA_W/7).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  in_data valid
- in_ready  out  1  encoder can accept a value this cycle
- in_data  in  DATA_W  value to encode
- in_zigzag  in  1  apply zigzag transform to this value; ignored unless VARINT_ZIGZAG_EN
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  8  encoded byte; [7] = continuation, [6:0] = payload group
- out_last  out  1  current byte is the final byte of the value
- out_len  out  LEN_W  total byte count of the value; valid when out_valid & out_last, else 0

## Operation
- State machine has two states, IDLE and EMIT. The registers are shreg[DATA_W-1:0] and cnt[LEN_W-1:0].
- IDLE: in_ready=1 and out_valid=0. On in_valid&in_ready: shreg<=xform(in_data), cnt<=1, go to EMIT.
- EMIT: out_valid=1.
  - out_data[6:0]=shreg[6:0].
  - cont=|shreg[DATA_W-1:7]; out_data[7]=cont; out_last=~cont; out_len=out_last?cnt:0.
- EMIT handshake with cont=1: shreg<=shreg>>7 (logical, zero fill) and cnt<=cnt+1.
- EMIT handshake with cont=0 (last byte):
  - in_ready=out_ready. This is a combinational path from out_ready and is permitted.
  - If in_valid is also high, load the new value, set cnt<=1 and stay in EMIT.
  - Otherwise go to IDLE.
- Value 0 encodes as the single byte 0x00 with out_last=1 and out_len=1.
- cnt never exceeds MAX_BYTES. For DATA_W=64 the tenth byte carries at most 1 payload bit (0x01).
- Outputs are stable while out_valid&~out_ready; no byte is dropped or duplicated.
- Undefined state returns to IDLE.

## Timing
- Reset values: state=IDLE, shreg=0, cnt=0, out_valid=0, out_last=0, out_len=0, out_data=0x00. in_ready is forced to 0 while reset is high and is 1 in the first cycle after reset deasserts.
- Latency: the first byte is valid the cycle after input acceptance.
- Throughput: one byte per cycle under continuous out_ready. An N-byte value occupies N cycles with no bubble between values when in_valid is held.
- Reset mid-EMIT aborts the value. Partial bytes already emitted stand, and downstream is responsible for framing via out_last.
- in_valid without in_ready has no effect. in_data is sampled only on the handshake cycle.

## Configuration
- VARINT_ZIGZAG_EN defined:
  - xform(x) = in_zigzag ? ((x<<1) ^ {DATA_W{x[DATA_W-1]}}) : x. This is the protobuf sint encoding.
  - The transform is computed combinationally on the accept cycle; there is no added latency.
- Not defined: xform(x)=x, in_zigzag is unused, and no zigzag logic is synthesised.

## Structure
- varint_pkg holds:
  - the state enum (IDLE, EMIT);
  - a function varint_max_bytes(int w) returning ceil(w/7);
  - a function varint_len(value, width) for reference-model use in benches.
- One natural sub-module is varint_zigzag, a combinational DATA_W-parametrised transform instantiated only under VARINT_ZIGZAG_EN.

## Test plan
- Basic encodings, DATA_W=32, out_ready=1:
  - in_data=0 -> 0x00, last=1, len=1.
  - in_data=300 -> 0xAC, 0x02, len=2.
  - in_data=0xFFFFFFFF -> FF FF FF FF 0F, len=5.
- DATA_W=64, in_data=0xFFFF_FFFF_FFFF_FFFF -> nine 0xFF bytes then 0x01, len=10.
- Backpressure: encode 300 while out_ready toggles 0,1,0,0,1. Required response: 0xAC is held stable until its handshake, then 0x02, with no duplicates.
- Back-to-back: in_valid held with 1, 128, 5 -> bytes 01 | 80 01 | 05. out_last is set on bytes 1, 3 and 4, there are no idle cycles, and in_ready pulses on each last-byte handshake.
- VARINT_ZIGZAG_EN, DATA_W=32:
  - in_data=0xFFFFFFFF (-1) with in_zigzag=1 -> 0x01.
  - in_data=1 with in_zigzag=1 -> 0x02.
  - Same inputs with in_zigzag=0 -> FF FF FF FF 0F and 0x01 respectively.
- Reset asserted on the second byte of 300 -> next cycle out_valid=0 and cnt=0; after release, in_ready=1 and encoding 5 yields 0x05 with len=1.
